// File: rtl/fsm_mur_tbl_if.sv
// rtl/fsm_mur_tbl_if.sv - bus bundle for the table-driven FSM with MISR BIST
interface fsm_mur_tbl_if #(
  parameter int SW   = 4,
  parameter int IW   = 4,
  parameter int SIGW = 16
);
  logic [IW-1:0]    sig_in;
  logic [SW-1:0]    state_o;
  logic             start_bist;
  logic             rst_state;
  logic             tbl_we;
  logic [SW+IW-1:0] tbl_addr;
  logic [SW-1:0]    tbl_wdata;
  logic             bist_busy;
  logic             bist_done;
  logic [SIGW-1:0]  bist_sig;

  modport master (
    output sig_in, start_bist, rst_state, tbl_we, tbl_addr, tbl_wdata,
    input  state_o, bist_busy, bist_done, bist_sig
  );

  modport slave (
    input  sig_in, start_bist, rst_state, tbl_we, tbl_addr, tbl_wdata,
    output state_o, bist_busy, bist_done, bist_sig
  );
endinterface

// File: rtl/fsm_mur_tbl.sv
// rtl/fsm_mur_tbl.sv - table-driven Moore FSM with MISR self-test scan of its table
module fsm_mur_tbl #(
  parameter int              SW   = 4,
  parameter int              IW   = 4,
  parameter int              SIGW = 16,
  parameter logic [SIGW-1:0] SEED = {SIGW{1'b1}},
  parameter logic [SIGW-1:0] TAPS = 16'hB400
) (
  input  logic          clk,
  input  logic          rst,
  fsm_mur_tbl_if.slave  bus
);
  localparam int AW = SW + IW;
  localparam int NE = 1 << AW;

  typedef enum logic [1:0] {RUN = 2'd0, BIST = 2'd1, DONE = 2'd2} ctrl_e;

  ctrl_e           ctrl_q, ctrl_d;
  logic [SW-1:0]   state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [SIGW-1:0] sig_q, sig_d;
  logic [SW-1:0]   tbl_q [NE];

  logic [SW-1:0]   rd_run;
  logic [SW-1:0]   rd_bist;
  logic            fb;
  logic [SIGW-1:0] misr_next;
  logic            we_ok;

  // Table lookups: the array is registered, so a same-cycle write is not yet visible here
  assign rd_run    = tbl_q[{state_q, bus.sig_in}];
  assign rd_bist   = tbl_q[cnt_q];
  assign fb        = ^(sig_q & TAPS);
  assign misr_next = {sig_q[SIGW-2:0], fb} ^ {{(SIGW-SW){1'b0}}, rd_bist};
  assign we_ok     = bus.tbl_we && (ctrl_q == RUN);

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= RUN;
      state_q <= '0;
      cnt_q   <= '0;
      sig_q   <= SEED;
    end else begin
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
    end
  end

  // Transition table storage; writes accepted only while running
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NE; i++) tbl_q[i] <= '0;
    end else if (we_ok) begin
      tbl_q[bus.tbl_addr] <= bus.tbl_wdata;
    end
  end

  // Next-state logic: normal stepping, scan start, scan compaction and abort
  always_comb begin
    ctrl_d  = ctrl_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    case (ctrl_q)
      RUN: begin
        if (bus.rst_state) begin
          state_d = '0;
        end else if (bus.start_bist) begin
          state_d = '0;
          cnt_d   = '0;
          sig_d   = SEED;
          ctrl_d  = BIST;
        end else begin
          state_d = rd_run;
        end
      end
      BIST: begin
        state_d = '0;
        if (bus.rst_state) begin
          cnt_d  = '0;
          sig_d  = SEED;
          ctrl_d = RUN;
        end else begin
          sig_d = misr_next;
          if (&cnt_q) begin
            ctrl_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = '0;
        ctrl_d  = RUN;
        if (bus.rst_state) sig_d = SEED;
      end
      default: begin
        state_d = '0;
        ctrl_d  = RUN;
      end
    endcase
  end

  // Moore outputs decoded from the control state
  always_comb begin
    bus.state_o   = state_q;
    bus.bist_sig  = sig_q;
    bus.bist_busy = (ctrl_q == BIST);
    bus.bist_done = (ctrl_q == DONE);
  end
endmodule

// File: tb/tb_fsm_mur_tbl.sv
// tb/tb_fsm_mur_tbl.sv - self-checking bench for fsm_mur_tbl
module tb_fsm_mur_tbl;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  fsm_mur_tbl_if #(.SW(4), .IW(4), .SIGW(16)) bus_if ();

  fsm_mur_tbl #(.SW(4), .IW(4), .SIGW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  logic [3:0]  ref_tbl [256];
  logic [3:0]  ref_state;
  logic [15:0] ref_sig;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signature of the whole table computed straight from the compaction rule
  function automatic logic [15:0] model_sig();
    logic [15:0] s;
    logic        f;
    s = 16'hFFFF;
    for (int e = 0; e < 256; e++) begin
      f = ^(s & 16'hB400);
      s = {s[14:0], f} ^ {12'h000, ref_tbl[e]};
    end
    return s;
  endfunction

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // One RUN-mode cycle: advance the model from the current inputs, then clock
  task automatic tick_run();
    logic [3:0] nxt;
    if (rst) begin
      for (int i = 0; i < 256; i++) ref_tbl[i] = 4'h0;
      ref_state = 4'h0;
      ref_sig   = 16'hFFFF;
    end else begin
      nxt = bus_if.rst_state ? 4'h0 : ref_tbl[{ref_state, bus_if.sig_in}];
      if (bus_if.tbl_we) ref_tbl[bus_if.tbl_addr] = bus_if.tbl_wdata;
      ref_state = nxt;
    end
    edge1();
  endtask

  task automatic idle_inputs();
    bus_if.start_bist = 1'b0;
    bus_if.rst_state  = 1'b0;
    bus_if.tbl_we     = 1'b0;
    bus_if.tbl_addr   = 8'h00;
    bus_if.tbl_wdata  = 4'h0;
  endtask

  // Full scan with busy/done timing checks; writes and starts are thrown at it to prove they are ignored
  task automatic run_bist(output logic [15:0] got);
    logic [15:0] exp_sig;
    exp_sig = model_sig();
    bus_if.start_bist = 1'b1;
    bus_if.rst_state  = 1'b0;
    edge1();
    for (int i = 1; i <= 256; i++) begin
      chk("bist_busy_in_scan", {31'd0, bus_if.bist_busy}, 32'd1);
      chk("bist_done_in_scan", {31'd0, bus_if.bist_done}, 32'd0);
      chk("state_held_in_scan", {28'd0, bus_if.state_o}, 32'd0);
      bus_if.start_bist = 1'($urandom_range(0, 1));
      bus_if.tbl_we     = 1'($urandom_range(0, 1));
      bus_if.tbl_addr   = 8'($urandom);
      bus_if.tbl_wdata  = 4'($urandom);
      bus_if.sig_in     = 4'($urandom);
      edge1();
    end
    chk("bist_done_pulse", {31'd0, bus_if.bist_done}, 32'd1);
    chk("bist_busy_at_done", {31'd0, bus_if.bist_busy}, 32'd0);
    chk("bist_sig_final", {16'd0, bus_if.bist_sig}, {16'd0, exp_sig});
    got = bus_if.bist_sig;
    idle_inputs();
    edge1();
    chk("bist_done_one_cycle", {31'd0, bus_if.bist_done}, 32'd0);
    chk("bist_busy_after_done", {31'd0, bus_if.bist_busy}, 32'd0);
    chk("bist_sig_holds", {16'd0, bus_if.bist_sig}, {16'd0, exp_sig});
    ref_state = 4'h0;
    ref_sig   = exp_sig;
  endtask

  initial begin
    logic [15:0] sig_a, sig_b, sig_c;
    logic [7:0]  flip_addr;
    int          done_seen;

    rst = 1'b1;
    bus_if.sig_in = 4'h0;
    idle_inputs();
    for (int i = 0; i < 256; i++) ref_tbl[i] = 4'h0;
    ref_state = 4'h0;
    ref_sig   = 16'hFFFF;
    repeat (3) edge1();
    rst = 1'b0;

    // Reset state and sweep of sig_in over an all-zero table
    chk("rst_state_o", {28'd0, bus_if.state_o}, 32'd0);
    chk("rst_busy", {31'd0, bus_if.bist_busy}, 32'd0);
    chk("rst_done", {31'd0, bus_if.bist_done}, 32'd0);
    chk("rst_sig", {16'd0, bus_if.bist_sig}, 32'h0000FFFF);
    for (int v = 0; v < 16; v++) begin
      bus_if.sig_in = 4'(v);
      tick_run();
      chk("sweep_state_o", {28'd0, bus_if.state_o}, 32'd0);
      chk("sweep_sig", {16'd0, bus_if.bist_sig}, 32'h0000FFFF);
      chk("sweep_busy", {31'd0, bus_if.bist_busy}, 32'd0);
    end

    // Table programming
    bus_if.sig_in = 4'h0;
    bus_if.tbl_we = 1'b1; bus_if.tbl_addr = 8'h03; bus_if.tbl_wdata = 4'h5;
    tick_run();
    bus_if.tbl_addr = 8'h5F; bus_if.tbl_wdata = 4'hA;
    tick_run();
    bus_if.tbl_we = 1'b0;
    bus_if.sig_in = 4'h3; tick_run();
    chk("prog_0_3", {28'd0, bus_if.state_o}, 32'h5);
    bus_if.sig_in = 4'hF; tick_run();
    chk("prog_5_F", {28'd0, bus_if.state_o}, 32'hA);
    bus_if.sig_in = 4'h0; tick_run();
    chk("prog_A_0", {28'd0, bus_if.state_o}, 32'h0);

    // Same-cycle write/read collision returns the old entry
    bus_if.sig_in = 4'h3;
    bus_if.tbl_we = 1'b1; bus_if.tbl_addr = 8'h03; bus_if.tbl_wdata = 4'h7;
    tick_run();
    bus_if.tbl_we = 1'b0;
    chk("collide_old", {28'd0, bus_if.state_o}, 32'h5);
    bus_if.sig_in = 4'h0; tick_run();
    chk("collide_back0", {28'd0, bus_if.state_o}, 32'h0);
    bus_if.sig_in = 4'h3; tick_run();
    chk("collide_new", {28'd0, bus_if.state_o}, 32'h7);

    // Fill the table randomly, then random running against the model
    for (int a = 0; a < 256; a++) begin
      bus_if.tbl_we = 1'b1; bus_if.tbl_addr = 8'(a); bus_if.tbl_wdata = 4'($urandom);
      bus_if.sig_in = 4'($urandom);
      bus_if.rst_state = ($urandom_range(0, 19) == 0);
      tick_run();
      chk("fill_state_o", {28'd0, bus_if.state_o}, {28'd0, ref_state});
    end
    for (int k = 0; k < 300; k++) begin
      bus_if.tbl_we    = ($urandom_range(0, 3) == 0);
      bus_if.tbl_addr  = 8'($urandom);
      bus_if.tbl_wdata = 4'($urandom);
      bus_if.sig_in    = 4'($urandom);
      bus_if.rst_state = ($urandom_range(0, 19) == 0);
      tick_run();
      chk("rand_state_o", {28'd0, bus_if.state_o}, {28'd0, ref_state});
      chk("rand_busy", {31'd0, bus_if.bist_busy}, 32'd0);
    end
    idle_inputs();

    // BIST, rerun, single-entry flip
    run_bist(sig_a);
    run_bist(sig_b);
    chk("bist_rerun_same", {16'd0, sig_b}, {16'd0, sig_a});
    flip_addr = 8'($urandom);
    bus_if.rst_state = 1'b1;
    bus_if.tbl_we = 1'b1; bus_if.tbl_addr = flip_addr;
    bus_if.tbl_wdata = ref_tbl[flip_addr] ^ 4'h1;
    tick_run();
    idle_inputs();
    run_bist(sig_c);
    n_cmp++;
    assert (sig_c !== sig_a) else begin
      n_bad++;
      $error("FAIL bist_flip_changes observed=%0h expected_not=%0h", sig_c, sig_a);
    end

    // Abort mid-scan
    bus_if.start_bist = 1'b1;
    edge1();
    bus_if.start_bist = 1'b0;
    repeat (99) edge1();
    chk("abort_pre_busy", {31'd0, bus_if.bist_busy}, 32'd1);
    bus_if.rst_state = 1'b1;
    edge1();
    bus_if.rst_state = 1'b0;
    ref_state = 4'h0;
    chk("abort_busy", {31'd0, bus_if.bist_busy}, 32'd0);
    chk("abort_done", {31'd0, bus_if.bist_done}, 32'd0);
    chk("abort_sig", {16'd0, bus_if.bist_sig}, 32'h0000FFFF);
    chk("abort_state_o", {28'd0, bus_if.state_o}, 32'd0);
    done_seen = 0;
    for (int k = 0; k < 200; k++) begin
      bus_if.sig_in = 4'($urandom);
      tick_run();
      if (bus_if.bist_done || bus_if.bist_busy) done_seen++;
    end
    chk("abort_no_done_later", 32'(done_seen), 32'd0);
    chk("abort_state_track", {28'd0, bus_if.state_o}, {28'd0, ref_state});

    // rst_state beats start_bist in RUN
    bus_if.rst_state = 1'b1; bus_if.start_bist = 1'b1;
    tick_run();
    idle_inputs();
    chk("prio_no_busy", {31'd0, bus_if.bist_busy}, 32'd0);
    chk("prio_state_o", {28'd0, bus_if.state_o}, 32'd0);
    bus_if.sig_in = 4'h0;
    tick_run();
    chk("prio_no_busy_later", {31'd0, bus_if.bist_busy}, 32'd0);
    chk("prio_sig_kept", {16'd0, bus_if.bist_sig}, 32'h0000FFFF);

    // rst in the middle of a scan
    bus_if.start_bist = 1'b1;
    edge1();
    bus_if.start_bist = 1'b0;
    repeat (50) edge1();
    rst = 1'b1;
    tick_run();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, bus_if.bist_busy}, 32'd0);
    chk("midrst_done", {31'd0, bus_if.bist_done}, 32'd0);
    chk("midrst_sig", {16'd0, bus_if.bist_sig}, 32'h0000FFFF);
    chk("midrst_state_o", {28'd0, bus_if.state_o}, 32'd0);
    bus_if.sig_in = 4'h3; tick_run();
    chk("midrst_tbl_cleared", {28'd0, bus_if.state_o}, {28'd0, ref_state});
    chk("midrst_tbl_zero", {28'd0, bus_if.state_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fsm_mur_tbl.md
FSM_MUR_TBL -- requirements
Module: fsm_mur_tbl

Interface
REQ-001 SHALL have parameter SW, default 4: state width in bits.
REQ-002 SHALL have parameter IW, default 4: input width in bits; SW+IW SHALL be at most 12.
REQ-003 SHALL have parameter SIGW, default 16: BIST signature width; SIGW SHALL be greater than SW.
REQ-004 SHALL have parameter SEED, default all-ones: MISR start value.
REQ-005 SHALL have parameter TAPS, default 16'hB400: MISR feedback mask.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 sig_in  input  IW  FSM input vector.
REQ-009 state_o  output  SW  current FSM state (Moore output).
REQ-010 start_bist  input  1  request a BIST table scan.
REQ-011 rst_state  input  1  force state to 0; also aborts BIST.
REQ-012 tbl_we  input  1  transition-table write enable.
REQ-013 tbl_addr  input  SW+IW  table write address {state, input}.
REQ-014 tbl_wdata  input  SW  next-state value to write.
REQ-015 bist_busy  output  1  high while scanning.
REQ-016 bist_done  output  1  one-cycle completion pulse.
REQ-017 bist_sig  output  SIGW  MISR signature.

Function
REQ-018 SHALL hold a transition table of 2^(SW+IW) entries, each SW bits wide, indexed {state_ff, sig_in}.
REQ-019 SHALL implement a control FSM with states RUN, BIST and DONE.
REQ-020 In RUN, state_ff SHALL load table[{state_ff, sig_in}] each cycle; rst_state=1 SHALL instead load 0.
REQ-021 A table write SHALL take effect on the next cycle; a same-cycle read of the same address SHALL return the old entry.
REQ-022 In RUN, start_bist=1 (with rst_state=0) SHALL load state_ff=0, counter=0 and bist_sig=SEED, and SHALL enter BIST on the next cycle.
REQ-023 In BIST, state_ff SHALL hold 0, bist_busy SHALL be 1, and each cycle SHALL read entry e=table[cnt].
REQ-024 MISR update each BIST cycle: fb = XOR-reduce(sig AND TAPS); sig_next = {sig[SIGW-2:0], fb} XOR zero-extended e.
REQ-025 After the entry at cnt=2^(SW+IW)-1 is compacted, the block SHALL enter DONE: bist_done=1 and bist_busy=0 for exactly one cycle, then return to RUN.
REQ-026 Timing: with start_bist sampled at edge T, bist_busy SHALL be high for cycles T+1 to T+2^(SW+IW), and bist_done SHALL be high at T+2^(SW+IW)+1.
REQ-027 bist_sig SHALL hold its final value until the next BIST start, a BIST abort, or rst.
REQ-028 tbl_we SHALL be ignored in BIST and DONE; start_bist SHALL be ignored in BIST and DONE.
REQ-029 rst_state=1 in BIST or DONE SHALL force RUN on the next cycle with state_ff=0, bist_busy=0, bist_sig=SEED and no bist_done pulse.
REQ-030 If rst_state and start_bist are both 1 in RUN, rst_state SHALL win and BIST SHALL not start.
REQ-031 The counter SHALL be SW+IW bits wide and SHALL NOT wrap back into a second scan.

Reset
REQ-032 rst=1 SHALL set state_o=0, control FSM=RUN, counter=0, bist_busy=0, bist_done=0, bist_sig=SEED, and every table entry to 0.
REQ-033 rst SHALL take priority over every other input, including during BIST.

Verification
REQ-034 Reset: pulse rst, sweep sig_in 0..F -> state_o=0 throughout, bist_sig=16'hFFFF, bist_busy=0.
REQ-035 Table program: write {0,3}->5 and {5,F}->A; drive sig_in 3 then F -> state_o=5 then A; then sig_in=0 -> state_o=0.
REQ-036 Collision: in state 0 with sig_in=3, write {0,3}->7 in the same cycle -> next state_o=5 (old entry); the following visit to {0,3} -> 7.
REQ-037 BIST: start_bist at T -> bist_busy high T+1..T+256, bist_done high only at T+257; bist_sig equals the reference-model MISR; an identical rerun gives an identical sig; flipping one entry changes sig.
REQ-038 Abort: rst_state at T+100 during BIST -> bist_busy=0 at T+101, no bist_done, bist_sig=16'hFFFF, state_o=0.
REQ-039 Priority: start_bist and rst_state high together in RUN -> no BIST; rst=1 mid-BIST -> full reset values per REQ-032.
